// File: rtl/axi_wr_addr_gen_if.sv
// AXI3 write-address channel bundle between the address generator (master)
// and the interconnect (slave).
interface axi_wr_addr_gen_if #(
    parameter int ID_MAX_WIDTH = 12,
    parameter int ADDR_WIDTH   = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ID_MAX_WIDTH-1:0] awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awbrust;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awbrust,
               awlock, awcache, awprot, awqos,
        input  awready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awbrust,
               awlock, awcache, awprot, awqos,
        output awready
    );
endinterface

// File: rtl/axi_wr_addr_gen.sv
// Splits linear write commands into AXI3 INCR bursts (<=16 beats, never
// crossing a 4 KB page) and issues them on the AW channel.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// CALC  | size the next burst against remaining beats, 16 and the 4 KB page
// ISSUE | awvalid high until the slave accepts the burst
module axi_wr_addr_gen #(
    parameter int ID_MAX_WIDTH = 12,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_BYTES   = 8,
    parameter int BEATS_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [BEATS_WIDTH-1:0]  cmd_beats,
    input  logic [ID_MAX_WIDTH-1:0] cmd_id,
    output logic                    cmd_done,
    axi_wr_addr_gen_if.master       aw
);
    localparam int SIZE = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [BEATS_WIDTH-1:0]  remaining_q, remaining_d;
    logic [ID_MAX_WIDTH-1:0] id_q, id_d;
    logic [4:0]              n_q, n_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [3:0]              awlen_q, awlen_d;
    logic [ID_MAX_WIDTH-1:0] awid_q, awid_d;
    logic                    awvalid_q, awvalid_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    cmd_done_q, cmd_done_d;

    logic [12:0]             bnd_bytes;
    logic [12:0]             bnd_beats;
    logic [4:0]              burst_beats;

    // Beats left before the 4 KB page ends; 13 bits so a page-aligned
    // address yields the full 4096 bytes.
    always_comb begin
        bnd_bytes   = 13'd4096 - {1'b0, cur_addr_q[11:0]};
        bnd_beats   = bnd_bytes >> SIZE;
        burst_beats = 5'd16;
        if (bnd_beats < 13'(burst_beats))
            burst_beats = bnd_beats[4:0];
        if (remaining_q < BEATS_WIDTH'(burst_beats))
            burst_beats = remaining_q[4:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            id_q        <= '0;
            n_q         <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awid_q      <= '0;
            awvalid_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            cmd_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            id_q        <= id_d;
            n_q         <= n_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awid_q      <= awid_d;
            awvalid_q   <= awvalid_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_done_q  <= cmd_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        id_d        = id_q;
        n_d         = n_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awid_d      = awid_q;
        cmd_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cur_addr_d  = cmd_addr & ALIGN_MASK;
                    remaining_d = cmd_beats;
                    id_d        = cmd_id;
                    if (cmd_beats == '0)
                        cmd_done_d = 1'b1;
                    else
                        state_d = CALC;
                end
            end
            CALC: begin
                awaddr_d = cur_addr_q;
                awlen_d  = 4'(burst_beats - 5'd1);
                awid_d   = id_q;
                n_d      = burst_beats;
                state_d  = ISSUE;
            end
            ISSUE: begin
                if (awvalid_q && aw.awready) begin
                    cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(n_q) << SIZE);
                    remaining_d = remaining_q - BEATS_WIDTH'(n_q);
                    if (remaining_q == BEATS_WIDTH'(n_q)) begin
                        cmd_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered from the next state so no output depends on awready
        // combinationally.
        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == ISSUE);
    end

    assign cmd_ready  = cmd_ready_q;
    assign cmd_done   = cmd_done_q;

    assign aw.awvalid = awvalid_q;
    assign aw.awid    = awid_q;
    assign aw.awaddr  = awaddr_q;
    assign aw.awlen   = awlen_q;
    assign aw.awsize  = 3'(SIZE);
    assign aw.awbrust = 2'b01;
    assign aw.awlock  = 2'b00;
    assign aw.awcache = 4'b0011;
    assign aw.awprot  = 3'b000;
    assign aw.awqos   = 4'b0000;
endmodule

// File: doc/axi_wr_addr_gen.md
Name: axi_wr_addr_gen

Overview:
- Write-address master stage. Takes linear write commands (start address, beat count, ID) from a DMA/feature-map writer.
- Splits each command into AXI3 INCR bursts of at most 16 beats that never cross a 4 KB boundary.
- Drives the master side of the AXI write-address channel and pulses a done strobe when a command's last burst address is accepted.

Parameters:
- ID_MAX_WIDTH, 12, width of cmd_id and awid.
- ADDR_WIDTH, 32, address width.
- DATA_BYTES, 8, bytes per beat (power of 2, 1..128); awsize = log2(DATA_BYTES).
- BEATS_WIDTH, 16, width of the command beat count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  ADDR_WIDTH  start byte address; must be DATA_BYTES-aligned.
- cmd_beats  in  BEATS_WIDTH  total beats to write; 0 is legal.
- cmd_id  in  ID_MAX_WIDTH  transaction ID.
- cmd_done  out  1  one-cycle pulse when the command is fully issued.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- awid  out  ID_MAX_WIDTH  equals the latched cmd_id.
- awaddr  out  ADDR_WIDTH  burst start address.
- awlen  out  4  beats-1.
- awsize  out  3  constant log2(DATA_BYTES).
- awbrust  out  2  constant 2'b01 (INCR).
- awlock  out  2  constant 2'b00.
- awcache  out  4  constant 4'b0011.
- awprot  out  3  constant 3'b000.
- awqos  out  4  constant 4'b0000.

Behaviour:
- Reset (async, while rst=1): state=IDLE; cmd_ready=0, cmd_done=0, awvalid=0, awid=0, awaddr=0, awlen=0; internal cur_addr and remaining are cleared. Constant outputs hold their constant values.
- FSM states: IDLE, CALC, ISSUE.
- IDLE:
  - cmd_ready=1 (registered; high the cycle after reset release).
  - On handshake, latch cur_addr=cmd_addr, remaining=cmd_beats, id=cmd_id.
  - If cmd_beats=0: pulse cmd_done next cycle and stay in IDLE; no AW transfer.
  - Otherwise go to CALC.
  - cmd_ready=0 in every state except IDLE.
- CALC (1 cycle):
  - bnd = (4096 - cur_addr[11:0]) / DATA_BYTES, computed in 13-bit arithmetic (range 1..4096/DATA_BYTES).
  - n = min(remaining, 16, bnd).
  - Register awaddr=cur_addr, awlen=n-1, awid=id. Go to ISSUE.
- ISSUE:
  - awvalid=1. awaddr, awlen and awid are held stable while awvalid=1 & awready=0.
  - Deassertion of awvalid only happens after a handshake.
  - On awvalid & awready:
    - cur_addr += n*DATA_BYTES; remaining -= n; awvalid=0 next cycle.
    - If the new remaining is 0: cmd_done=1 for one cycle and go to IDLE.
    - Otherwise go to CALC.
- Latency:
  - Handshake in cycle T gives awvalid=1 at T+2.
  - Between bursts, awvalid is low for exactly one cycle (the CALC cycle).
  - After the last burst's handshake at T, cmd_done=1 at T+1 and cmd_ready=1 at T+1.
- No combinational path from awready to any output.
- Address wrap past 2^ADDR_WIDTH is modulo; it is not checked.
- Misaligned cmd_addr is undefined. Low log2(DATA_BYTES) address bits are forced to 0 when latched.
- Reset asserted mid-burst: awvalid drops immediately (async). The pending command is discarded with no cmd_done.

Test Plan:
- DATA_BYTES=8, cmd_addr=0x1000, beats=16, awready=1 -> one AW: awaddr=0x1000, awlen=15, awsize=3, awbrust=01. cmd_done one cycle after the handshake. awvalid first high 2 cycles after cmd accept.
- cmd_addr=0x0FC0, beats=20 -> AW1 0x0FC0 awlen=7 (4 KB split); AW2 0x1000 awlen=11; single cmd_done.
- cmd_addr=0x2000, beats=40, cmd_id=0xA5 -> AWs (0x2000, 15), (0x2080, 15), (0x2100, 7), all awid=0xA5. awvalid low exactly 1 cycle between bursts.
- awready held 0 for 5 cycles during ISSUE -> awvalid, awaddr, awlen, awid stable all 5 cycles; cmd_ready=0; transfer completes on the first awready=1.
- cmd_beats=0 -> cmd_done pulses the cycle after accept; awvalid never asserts; cmd_ready returns to 1.
- rst pulsed while awvalid=1 on the 2nd burst of a 40-beat command -> awvalid=0 during reset; no cmd_done. After release, cmd_ready=1 and a new 16-beat command issues normally.
